// File: rtl/tlc_multiway.sv
`default_nettype none
// ============================================================================
// Module   : tlc_multiway
// Brief    : N-approach round-robin traffic light controller with latched
//            pedestrian requests and an exclusive, counted-down WALK interval.
// Revision : 1.0 - initial release
// ============================================================================
module tlc_multiway #(
    parameter int N_DIR    = 2,
    parameter int CW       = 4,
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1,
    parameter int WALK_T   = 5,
    localparam int PW      = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [N_DIR-1:0] ped_req,
    output logic [N_DIR-1:0] red,
    output logic [N_DIR-1:0] yellow,
    output logic [N_DIR-1:0] green,
    output logic [N_DIR-1:0] ped_walk,
    output logic [CW-1:0]    ped_count,
    output logic [PW-1:0]    phase
);

    localparam logic [1:0] c_GREEN   = 2'd0;
    localparam logic [1:0] c_YELLOW  = 2'd1;
    localparam logic [1:0] c_ALL_RED = 2'd2;
    localparam logic [1:0] c_WALK    = 2'd3;

    localparam logic [PW-1:0] c_LAST_PHASE = PW'(N_DIR - 1);
    localparam logic [CW-1:0] c_GREEN_LD   = CW'(GREEN_T - 1);
    localparam logic [CW-1:0] c_YELLOW_LD  = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] c_ALLRED_LD  = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] c_WALK_LD    = CW'(WALK_T - 1);

    logic [1:0]       r_state;
    logic [PW-1:0]    r_phase;
    logic [CW-1:0]    r_timer;
    logic [N_DIR-1:0] r_ped_latch;
    logic [N_DIR-1:0] r_walk_mask;

    logic             w_expire;
    logic             w_enter_walk;
    logic [PW-1:0]    w_phase_next;
    logic [N_DIR-1:0] w_latch_next;

    assign w_expire     = tick && (r_timer == '0);
    assign w_enter_walk = w_expire && (r_state == c_ALL_RED) && (|r_ped_latch);
    // Explicit wrap keeps non-power-of-two N_DIR inside the valid index range
    assign w_phase_next = (r_phase == c_LAST_PHASE) ? '0 : r_phase + 1'b1;
    // New requests are OR-ed after the clear, so a press on the entry edge survives
    assign w_latch_next = (w_enter_walk ? '0 : r_ped_latch) | ped_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ALL_RED;
            r_phase     <= c_LAST_PHASE;
            r_timer     <= c_ALLRED_LD;
            r_ped_latch <= '0;
            r_walk_mask <= '0;
        end else begin
            r_ped_latch <= w_latch_next;
            if (tick && (r_timer != '0)) begin
                r_timer <= r_timer - 1'b1;
            end else if (w_expire) begin
                case (r_state)
                    c_GREEN: begin
                        r_state <= c_YELLOW;
                        r_timer <= c_YELLOW_LD;
                    end
                    c_YELLOW: begin
                        r_state <= c_ALL_RED;
                        r_timer <= c_ALLRED_LD;
                    end
                    c_ALL_RED: begin
                        if (|r_ped_latch) begin
                            r_state     <= c_WALK;
                            r_timer     <= c_WALK_LD;
                            r_walk_mask <= r_ped_latch;
                        end else begin
                            r_state <= c_GREEN;
                            r_timer <= c_GREEN_LD;
                            r_phase <= w_phase_next;
                        end
                    end
                    default: begin
                        r_state <= c_GREEN;
                        r_timer <= c_GREEN_LD;
                        r_phase <= w_phase_next;
                    end
                endcase
            end
        end
    end

    always_comb begin
        green  = '0;
        yellow = '0;
        for (int i = 0; i < N_DIR; i++) begin
            if (r_phase == PW'(i)) begin
                green[i]  = (r_state == c_GREEN);
                yellow[i] = (r_state == c_YELLOW);
            end
        end
        red       = ~(green | yellow);
        ped_walk  = (r_state == c_WALK) ? r_walk_mask : '0;
        ped_count = (r_state == c_WALK) ? r_timer : '0;
    end

    assign phase = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_tlc_multiway.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlc_multiway
// Brief    : Scoreboard bench for tlc_multiway, default and 3-approach builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlc_multiway;

    localparam int K_G = 0;
    localparam int K_Y = 1;
    localparam int K_AR = 2;
    localparam int K_W = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b1;
    logic [1:0] ped_req0 = '0;
    logic [2:0] ped_req1 = '0;

    logic [1:0] red0, yellow0, green0, walk0;
    logic [3:0] count0;
    logic [0:0] phase0;
    logic [2:0] red1, yellow1, green1, walk1;
    logic [3:0] count1;
    logic [1:0] phase1;

    always #5 clk = ~clk;

    tlc_multiway dut0 (
        .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req0),
        .red(red0), .yellow(yellow0), .green(green0),
        .ped_walk(walk0), .ped_count(count0), .phase(phase0)
    );

    tlc_multiway #(
        .N_DIR(3), .CW(4), .GREEN_T(2), .YELLOW_T(1), .ALLRED_T(1), .WALK_T(5)
    ) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req1),
        .red(red1), .yellow(yellow1), .green(green1),
        .ped_walk(walk1), .ped_count(count1), .phase(phase1)
    );

    typedef struct {
        int         id;
        logic [7:0] red, yel, grn, walk;
        logic [3:0] cnt;
        logic [2:0] ph;
    } obs_t;

    obs_t sbq[$];
    obs_t m_exp, m_act;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: current interval kind, served phase, its length and ticks consumed
    int nd_a[2] = '{2, 3};
    int gt_a[2] = '{8, 2};
    int yt_a[2] = '{2, 1};
    int at_a[2] = '{1, 1};
    int wt_a[2] = '{5, 5};
    int kind[2], ph[2], dur[2], el[2];
    logic [7:0] latch[2], mask[2];

    task automatic model_step(input int d, input bit rst, input bit tk, input logic [7:0] req);
        bit entered;
        entered = 1'b0;
        if (rst) begin
            kind[d] = K_AR; ph[d] = nd_a[d] - 1; dur[d] = at_a[d]; el[d] = 0;
            latch[d] = '0; mask[d] = '0;
            return;
        end
        if (tk) begin
            el[d]++;
            if (el[d] == dur[d]) begin
                el[d] = 0;
                case (kind[d])
                    K_G:  begin kind[d] = K_Y;  dur[d] = yt_a[d]; end
                    K_Y:  begin kind[d] = K_AR; dur[d] = at_a[d]; end
                    K_AR: begin
                        if (latch[d] != 0) begin
                            kind[d] = K_W; dur[d] = wt_a[d]; mask[d] = latch[d]; entered = 1'b1;
                        end else begin
                            kind[d] = K_G; dur[d] = gt_a[d]; ph[d] = (ph[d] + 1) % nd_a[d];
                        end
                    end
                    default: begin kind[d] = K_G; dur[d] = gt_a[d]; ph[d] = (ph[d] + 1) % nd_a[d]; end
                endcase
            end
        end
        latch[d] = (entered ? 8'h00 : latch[d]) | req;
    endtask

    function automatic obs_t model_out(input int d);
        obs_t o;
        o.id = d; o.red = '0; o.yel = '0; o.grn = '0;
        for (int i = 0; i < nd_a[d]; i++) begin
            if (kind[d] == K_G && i == ph[d]) o.grn[i] = 1'b1;
            else if (kind[d] == K_Y && i == ph[d]) o.yel[i] = 1'b1;
            else o.red[i] = 1'b1;
        end
        o.walk = (kind[d] == K_W) ? mask[d] : 8'h00;
        o.cnt  = (kind[d] == K_W) ? 4'(dur[d] - 1 - el[d]) : 4'd0;
        o.ph   = 3'(ph[d]);
        return o;
    endfunction

    function automatic obs_t dut_out(input int d);
        obs_t o;
        o.id = d;
        if (d == 0) begin
            o.red = {6'b0, red0}; o.yel = {6'b0, yellow0}; o.grn = {6'b0, green0};
            o.walk = {6'b0, walk0}; o.cnt = count0; o.ph = {2'b0, phase0};
        end else begin
            o.red = {5'b0, red1}; o.yel = {5'b0, yellow1}; o.grn = {5'b0, green1};
            o.walk = {5'b0, walk1}; o.cnt = count1; o.ph = {1'b0, phase1};
        end
        return o;
    endfunction

    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            m_exp = sbq.pop_front();
            m_act = dut_out(m_exp.id);
            vectors++;
            if (m_act.red !== m_exp.red || m_act.yel !== m_exp.yel || m_act.grn !== m_exp.grn ||
                m_act.walk !== m_exp.walk || m_act.cnt !== m_exp.cnt || m_act.ph !== m_exp.ph) begin
                miscompares++;
                $display("FAIL dut%0d outputs @%0t: got r=%b y=%b g=%b walk=%b cnt=%0d ph=%0d, want r=%b y=%b g=%b walk=%b cnt=%0d ph=%0d",
                         m_exp.id, $time, m_act.red, m_act.yel, m_act.grn, m_act.walk, m_act.cnt, m_act.ph,
                         m_exp.red, m_exp.yel, m_exp.grn, m_exp.walk, m_exp.cnt, m_exp.ph);
            end
        end
    end

    task automatic cycle(input bit rst, input bit tk, input logic [1:0] r0, input logic [2:0] r1);
        reset = rst; tick = tk; ped_req0 = r0; ped_req1 = r1;
        model_step(0, rst, tk, {6'b0, r0});
        model_step(1, rst, tk, {5'b0, r1});
        @(posedge clk);
        #1;
        sbq.push_back(model_out(0));
        sbq.push_back(model_out(1));
    endtask

    initial begin
        int k;
        // Reset, then free-running default sequence
        cycle(1'b1, 1'b1, 2'b00, 3'b000);
        cycle(1'b1, 1'b1, 2'b00, 3'b000);
        repeat (50) cycle(1'b0, 1'b1, 2'b00, 3'b000);

        // Single-cycle request during phase-0 green
        k = 0;
        while (k < 100 && !(kind[0] == K_G && ph[0] == 0)) begin
            cycle(1'b0, 1'b1, 2'b00, 3'b000);
            k++;
        end
        if (k >= 100) begin
            miscompares++;
            $display("FAIL wait_phase0_green: got timeout, want phase-0 green within 100 cycles");
        end
        cycle(1'b0, 1'b1, 2'b01, 3'b001);
        repeat (40) cycle(1'b0, 1'b1, 2'b00, 3'b000);

        // Slow strobe: one tick every third clock
        for (int i = 0; i < 90; i++) cycle(1'b0, (i % 3) == 2, 2'b00, 3'b000);

        // Request held through WALK re-arms the next WALK
        repeat (70) cycle(1'b0, 1'b1, 2'b10, 3'b010);
        repeat (30) cycle(1'b0, 1'b1, 2'b00, 3'b000);

        // Reset asserted in the middle of a WALK
        k = 0;
        while (k < 100 && !(kind[0] == K_W && el[0] == 2)) begin
            cycle(1'b0, 1'b1, 2'b01, 3'b100);
            k++;
        end
        if (k >= 100) begin
            miscompares++;
            $display("FAIL wait_walk: got timeout, want WALK within 100 cycles");
        end
        cycle(1'b1, 1'b1, 2'b01, 3'b100);
        repeat (30) cycle(1'b0, 1'b1, 2'b00, 3'b000);

        // Randomised strobe, requests and occasional reset
        repeat (600) begin
            logic [1:0] r0;
            logic [2:0] r1;
            for (int b = 0; b < 2; b++) r0[b] = ($urandom % 10) == 0;
            for (int b = 0; b < 3; b++) r1[b] = ($urandom % 10) == 0;
            cycle(($urandom % 200) == 0, $urandom_range(0, 3) != 0, r0, r1);
        end

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
